// File: rtl/dmem_responder.sv
// Data-memory responder: 128x32 store serving the core combinationally on loads and on the clock
// edge for stores, plus a req/ack host port that only gets the array while the core is idle.
module dmem_responder #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [6:0]       A,
  input  logic [31:0]      Data2Mem,
  output logic [31:0]      ReadDataMem,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [6:0]       host_addr,
  input  logic [31:0]      host_wdata,
  output logic             host_ack,
  output logic [31:0]      host_rdata,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             proto_err
);

  typedef enum logic {StIdle, StAck} state_e;

  state_e           state_q;
  logic [31:0]      mem_q [DEPTH];
  logic             host_ack_q;
  logic [31:0]      host_rdata_q;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic             proto_err_q, proto_err_d;

  logic core_rd, core_wr, grant;

  assign core_rd = ~CEN & ~OEN;
  assign core_wr = ~CEN & ~WEN;
  // The host is only granted while the core leaves CEN high, so the two never write together.
  assign grant   = (state_q == StIdle) & host_req & CEN;

  always_comb begin
    ReadDataMem = '0;
    if (core_rd) ReadDataMem = mem_q[A];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (core_wr) begin
      mem_q[A] <= Data2Mem;
    end else if (grant && host_we) begin
      mem_q[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      host_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q    <= StAck;
            host_ack_q <= 1'b1;
            if (!host_we) host_rdata_q <= mem_q[host_addr];
          end
        end
        StAck: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    if (core_rd && (rd_count_q != {CNT_W{1'b1}})) rd_count_d = rd_count_q + CNT_W'(1);
    if (core_wr && (wr_count_q != {CNT_W{1'b1}})) wr_count_d = wr_count_q + CNT_W'(1);
    if (core_rd && core_wr) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized core/host traffic against a
// word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        host_req, host_we;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic [15:0] rd_count, wr_count;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] m_mem [128];
  logic [15:0] m_rd, m_wr;
  logic        m_proto;
  logic        m_ack;
  logic [31:0] m_rdata;

  dmem_responder #(.DEPTH(128), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem),
    .ReadDataMem(ReadDataMem),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    m_rd = '0; m_wr = '0; m_proto = 1'b0; m_ack = 1'b0; m_rdata = '0;
  endfunction

  // Apply the effect of the coming rising edge to the model, using current inputs.
  function automatic void model_edge();
    logic rd, wr, gnt;
    rd  = !CEN && !OEN;
    wr  = !CEN && !WEN;
    gnt = host_req && CEN && !m_ack;
    if (gnt && !host_we) m_rdata = m_mem[host_addr];
    if (gnt && host_we) m_mem[host_addr] = host_wdata;
    if (wr) m_mem[A] = Data2Mem;
    if (rd && m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
    if (wr && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
    if (rd && wr) m_proto = 1'b1;
    m_ack = gnt;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_core();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_core();
    A = '0; Data2Mem = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    model_reset();
    #23;
    n_checks++;
    if (host_ack !== 1'b0 || host_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_host: ack=%b rdata=%h required 0/0", host_ack, host_rdata);
    end
    n_checks++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cnt: rd=%h wr=%h perr=%b required 0", rd_count, wr_count, proto_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    CEN = 1'b0; OEN = 1'b0; A = 7'd5;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_read: got %h required 0", ReadDataMem);
    end
    tick();
    n_checks++;
    if (rd_count !== 16'd1) begin
      n_errors++;
      $display("FAIL reset_rdcount: got %0d required 1", rd_count);
    end
    idle_core();
  endtask

  task automatic test_core_rw();
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = 7'd127; Data2Mem = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'h0) begin
      n_errors++;
      $display("FAIL core_wr_cycle: got %h required 0", ReadDataMem);
    end
    tick();
    WEN = 1'b1; OEN = 1'b0;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL core_load: got %h required deadbeef", ReadDataMem);
    end
    n_checks++;
    if (wr_count !== 16'd1) begin
      n_errors++;
      $display("FAIL core_wrcount: got %0d required 1", wr_count);
    end
    tick();
    n_checks++;
    if (rd_count !== 16'd2) begin
      n_errors++;
      $display("FAIL core_rdcount: got %0d required 2", rd_count);
    end
    idle_core();
  endtask

  task automatic test_conflict();
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL conflict_pre: proto_err=%b required 0", proto_err);
    end
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b0; A = 7'd3; Data2Mem = 32'h1234;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'h0) begin
      n_errors++;
      $display("FAIL conflict_old: got %h required 0", ReadDataMem);
    end
    tick();
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_errors++;
      $display("FAIL conflict_flag: got %b required 1", proto_err);
    end
    WEN = 1'b1;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'h1234) begin
      n_errors++;
      $display("FAIL conflict_data: got %h required 1234", ReadDataMem);
    end
    tick();
    idle_core();
    tick();
    tick();
    n_checks++;
    if (proto_err !== 1'b1 || rd_count !== m_rd || wr_count !== m_wr) begin
      n_errors++;
      $display("FAIL conflict_sticky: perr=%b rd=%0d wr=%0d required 1 %0d %0d",
               proto_err, rd_count, wr_count, m_rd, m_wr);
    end
  endtask

  task automatic test_host_arbitration();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd9; host_wdata = 32'hA5A5A5A5;
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (host_ack !== 1'b0) begin
        n_errors++;
        $display("FAIL arb_wait%0d: ack=%b required 0", i, host_ack);
      end
    end
    CEN = 1'b1;
    tick();
    n_checks++;
    if (host_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL arb_ack: ack=%b required 1", host_ack);
    end
    host_req = 1'b0;
    tick();
    n_checks++;
    if (host_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL arb_ack_width: ack=%b required 0", host_ack);
    end
    CEN = 1'b0; OEN = 1'b0; A = 7'd9;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'hA5A5A5A5) begin
      n_errors++;
      $display("FAIL arb_readback: got %h required a5a5a5a5", ReadDataMem);
    end
    tick();
    idle_core();
  endtask

  task automatic test_host_read();
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = 7'd20; Data2Mem = 32'h0000CAFE;
    tick();
    idle_core();
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd20; host_wdata = $urandom;
    tick();
    n_checks++;
    if (host_ack !== 1'b1 || host_rdata !== 32'h0000CAFE) begin
      n_errors++;
      $display("FAIL hrd_ack: ack=%b rdata=%h required 1/0000cafe", host_ack, host_rdata);
    end
    host_req = 1'b0;
    tick();
    n_checks++;
    if (host_ack !== 1'b0 || host_rdata !== 32'h0000CAFE) begin
      n_errors++;
      $display("FAIL hrd_hold: ack=%b rdata=%h required 0/0000cafe", host_ack, host_rdata);
    end
    CEN = 1'b0; OEN = 1'b0; A = 7'd20;
    #1;
    n_checks++;
    if (ReadDataMem !== 32'h0000CAFE) begin
      n_errors++;
      $display("FAIL hrd_nowrite: got %h required 0000cafe", ReadDataMem);
    end
    tick();
    idle_core();
  endtask

  task automatic test_back_to_back();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd30; host_wdata = 32'h3030_0001;
    tick();
    n_checks++;
    if (host_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ack1: ack=%b required 1", host_ack);
    end
    host_addr = 7'd31; host_wdata = 32'h3131_0002;
    tick();
    n_checks++;
    if (host_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_gap: ack=%b required 0", host_ack);
    end
    tick();
    n_checks++;
    if (host_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ack2: ack=%b required 1", host_ack);
    end
    host_req = 1'b0;
    tick();
    for (int i = 30; i < 32; i++) begin
      CEN = 1'b0; OEN = 1'b0; A = 7'(i);
      #1;
      n_checks++;
      if (ReadDataMem !== m_mem[i] || m_mem[i] === 32'h0) begin
        n_errors++;
        $display("FAIL b2b_mem%0d: got %h required %h", i, ReadDataMem, m_mem[i]);
      end
      tick();
    end
    idle_core();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_ack) begin
        host_req = 1'b0;
      end else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req   = 1'b1;
        host_we    = 1'($urandom);
        host_addr  = 7'($urandom_range(0, 15));
        host_wdata = $urandom;
      end
      CEN = 1'($urandom); WEN = 1'($urandom); OEN = 1'($urandom);
      A = 7'($urandom_range(0, 15)); Data2Mem = $urandom;
      #1;
      n_checks++;
      if (ReadDataMem !== ((!CEN && !OEN) ? m_mem[A] : 32'h0)) begin
        n_errors++;
        $display("FAIL rand_load%0d: got %h required %h", i, ReadDataMem,
                 (!CEN && !OEN) ? m_mem[A] : 32'h0);
      end
      n_checks++;
      if (host_ack !== m_ack || host_rdata !== m_rdata) begin
        n_errors++;
        $display("FAIL rand_host%0d: ack=%b rdata=%h required %b %h", i, host_ack, host_rdata,
                 m_ack, m_rdata);
      end
      tick();
    end
    idle_core();
    for (int i = 0; i < 3; i++) begin
      if (m_ack) host_req = 1'b0;
      tick();
    end
    host_req = 1'b0;
    n_checks++;
    if (rd_count !== m_rd || wr_count !== m_wr || proto_err !== m_proto) begin
      n_errors++;
      $display("FAIL rand_cnt: rd=%0d wr=%0d perr=%b required %0d %0d %b", rd_count, wr_count,
               proto_err, m_rd, m_wr, m_proto);
    end
    for (int i = 0; i < 16; i++) begin
      CEN = 1'b0; OEN = 1'b0; A = 7'(i);
      #1;
      n_checks++;
      if (ReadDataMem !== m_mem[i]) begin
        n_errors++;
        $display("FAIL rand_mem%0d: got %h required %h", i, ReadDataMem, m_mem[i]);
      end
      tick();
    end
    idle_core();
  endtask

  task automatic test_saturation_reset();
    CEN = 1'b0; OEN = 1'b0; WEN = 1'b1; A = 7'd0;
    repeat (65540) tick();
    n_checks++;
    if (rd_count !== 16'hFFFF || m_rd !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL sat_rd: got %h required ffff", rd_count);
    end
    idle_core();
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd40; host_wdata = 32'h7777_7777;
    CEN = 1'b0;
    tick();
    tick();
    n_checks++;
    if (host_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_wait: ack=%b required 0", host_ack);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: rd=%h wr=%h perr=%b required 0", rd_count, wr_count, proto_err);
    end
    CEN = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (host_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_noack: ack=%b required 0", host_ack);
    end
    @(negedge clk);
    host_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    n_checks++;
    if (host_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_noack2: ack=%b required 0", host_ack);
    end
    for (int i = 0; i < 128; i++) begin
      CEN = 1'b0; OEN = 1'b0; A = 7'(i);
      #1;
      n_checks++;
      if (ReadDataMem !== 32'h0) begin
        n_errors++;
        $display("FAIL rst_mem%0d: got %h required 0", i, ReadDataMem);
      end
      tick();
    end
    idle_core();
    n_checks++;
    if (rd_count !== 16'd128 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_after: rd=%0d perr=%b required 128 0", rd_count, proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_conflict();
    test_host_arbitration();
    test_host_read();
    test_back_to_back();
    test_random();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
